ddr3_cmd_monitor: RTL and testbench
===================================

Name: ddr3_cmd_monitor

Overview:
- Synthesizable DDR3 command-bus monitor for the simulation SoC bench; taps the controller-to-DRAM command pins alongside the DDR3 memory model.
- Decodes one command per clock, tracks open/closed state per bank, and checks tRCD/tRP/tRAS and protocol legality.
- Exposes per-command counters and error reporting. Parametrised in bank count, address width and timing, replacing ad-hoc waveform inspection.

Parameters:
BANKBITS, 3, bank address width; NBANK = 2**BANKBITS banks tracked
ABITS, 14, row/column address width on a
T_RCD, 5, min clocks ACT->RD/WR same bank
T_RP, 5, min clocks PRE->ACT same bank
T_RAS, 15, min clocks ACT->PRE same bank
CNT_WIDTH, 32, width of every command/error counter

Ports:
clk  in  1  sampling clock, one DRAM command slot per rising edge
rst  in  1  asynchronous active-high reset
cke  in  1  clock enable; low = no command decoded
cs_n, ras_n, cas_n, we_n  in  1 each  command pins
ba  in  BANKBITS  bank address
a  in  ABITS  address; a[10] = auto-precharge/all-banks bit
bank_open  out  NBANK  bit i = bank i open
cnt_act, cnt_pre, cnt_rd, cnt_wr, cnt_ref, cnt_mrs  out  CNT_WIDTH each  command counters
err_valid  out  1  one-cycle pulse per erroneous command
err_code  out  3  code of current error
err_bank  out  BANKBITS  bank of current error
err_count  out  CNT_WIDTH  number of erroneous commands
first_err_code  out  3  sticky code of first error, 0 = none
first_err_bank  out  BANKBITS  sticky bank of first error

Behaviour:
- Reset (async, all outputs): bank_open=0, counters=0, err_valid=0, err_code=0, err_bank=0, first_err_*=0; all bank timers saturated, so first ACT is legal.
- Decode is valid only when cke=1 and cs_n=0. {ras_n,cas_n,we_n}: 011 ACT, 010 PRE (a[10]=1 -> PREA), 101 RD, 100 WR, 001 REF, 000 MRS, 110 ZQ, 111 NOP. ZQ/NOP/undecoded: no state change.
- Per-bank timer tmr[i]: cleared to 1 on the clock after an ACT or an effective PRE to bank i, then increments each clock, saturating at max(T_RCD,T_RP,T_RAS). At cycle n, tmr = n - cycle of last ACT/PRE.
- Checks (codes):
  - 1 ACT to an open bank.
  - 2 RD/WR to a closed bank.
  - 3 RD/WR with tmr < T_RCD.
  - 4 ACT with tmr < T_RP.
  - 5 PRE/PREA on an open bank with tmr < T_RAS.
  - 6 REF while any bank is open.
- Erroneous commands still update state:
  - ACT opens the bank.
  - PRE/PREA close the bank(s) and restart their timers.
  - RD/WR with a[10]=1 (auto-precharge) on an open bank closes it after the access, restarting the timer; the tRAS check is not applied.
- PRE to a closed bank: legal, no timer change. PREA: checks every open bank; on multiple violations, report the lowest bank index; one error event.
- Error priority per command: 1/2 before 3/4; only one code per command.
- Outputs are registered with latency 1:
  - err_valid/err_code/err_bank assert on the clock after the command edge; code and bank return to 0 when err_valid=0.
  - bank_open and counters reflect a command one clock after its edge.
- Counters increment by 1 per decoded command (PREA counts as one PRE) and saturate at all-ones. err_count saturates the same way.
- first_err_code/first_err_bank latch on the first err_valid after reset and hold until rst.
- cke=0: commands are ignored, timers keep running.
- Reset mid-sequence: state returns to reset values immediately; no error is reported for commands interrupted by reset.

Test Plan:
- Reset, then ACT b2 at t0, RD b2 at t0+5, PRE b2 at t0+15, ACT b2 at t0+20 -> no err_valid; cnt_act=2, cnt_rd=1, cnt_pre=1; bank_open=0x04 at end.
- ACT b1 at t0, WR b1 at t0+4 -> err_valid one clock later, err_code=3, err_bank=1; first_err_code=3; err_count=1.
- ACT b0, ACT b3, PREA at +10 -> err_code=5, err_bank=0; single event; bank_open=0 afterwards.
- RD b5 with nothing open -> code 2, bank 5; then REF with b0 open -> code 6; first_err_code remains 2, err_count=2.
- CKE=0 with ACT pattern on pins for 10 clocks -> no counter change, bank_open unchanged; assert rst mid-sequence with b4 open -> bank_open=0 and counters=0 immediately, next ACT b4 legal.
- Counter saturation: CNT_WIDTH=4, 20 NOP-separated legal REFs -> cnt_ref holds 15.

Source files
------------

// File: rtl/ddr3_cmd_monitor.sv
// DDR3 command-bus monitor: decodes one command per clock, tracks per-bank
// open state and ACT/PRE timers, flags timing/protocol violations and keeps
// saturating per-command and error counters. All outputs are registered.
module ddr3_cmd_monitor #(
    parameter int BANKBITS  = 3,
    parameter int ABITS     = 14,
    parameter int T_RCD     = 5,
    parameter int T_RP      = 5,
    parameter int T_RAS     = 15,
    parameter int CNT_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cke,
    input  logic                         cs_n,
    input  logic                         ras_n,
    input  logic                         cas_n,
    input  logic                         we_n,
    input  logic [BANKBITS-1:0]          ba,
    input  logic [ABITS-1:0]             a,
    output logic [(1<<BANKBITS)-1:0]     bank_open,
    output logic [CNT_WIDTH-1:0]         cnt_act,
    output logic [CNT_WIDTH-1:0]         cnt_pre,
    output logic [CNT_WIDTH-1:0]         cnt_rd,
    output logic [CNT_WIDTH-1:0]         cnt_wr,
    output logic [CNT_WIDTH-1:0]         cnt_ref,
    output logic [CNT_WIDTH-1:0]         cnt_mrs,
    output logic                         err_valid,
    output logic [2:0]                   err_code,
    output logic [BANKBITS-1:0]          err_bank,
    output logic [CNT_WIDTH-1:0]         err_count,
    output logic [2:0]                   first_err_code,
    output logic [BANKBITS-1:0]          first_err_bank
);

    localparam int NBANK  = 1 << BANKBITS;
    localparam int TMAX_A = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int TMAX   = (TMAX_A > T_RAS) ? TMAX_A : T_RAS;
    localparam int TW     = $clog2(TMAX + 1);

    typedef logic [TW-1:0] tmr_t;
    typedef logic [CNT_WIDTH-1:0] cnt_t;

    localparam tmr_t TMAX_T = tmr_t'(TMAX);
    localparam tmr_t TRCD_T = tmr_t'(T_RCD);
    localparam tmr_t TRP_T  = tmr_t'(T_RP);
    localparam tmr_t TRAS_T = tmr_t'(T_RAS);

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_ACT_OPEN = 3'd1;
    localparam logic [2:0] ERR_CLOSED   = 3'd2;
    localparam logic [2:0] ERR_TRCD     = 3'd3;
    localparam logic [2:0] ERR_TRP      = 3'd4;
    localparam logic [2:0] ERR_TRAS     = 3'd5;
    localparam logic [2:0] ERR_REF_OPEN = 3'd6;

    // {ras_n, cas_n, we_n} encodings
    typedef enum logic [2:0] {
        CMD_MRS = 3'b000,
        CMD_REF = 3'b001,
        CMD_PRE = 3'b010,
        CMD_ACT = 3'b011,
        CMD_WR  = 3'b100,
        CMD_RD  = 3'b101,
        CMD_ZQ  = 3'b110,
        CMD_NOP = 3'b111
    } cmd_e;

    cmd_e                     cmd;
    logic                     cmd_vld;
    logic                     ap;

    logic [NBANK-1:0]         bank_open_q, bank_open_d;
    logic [NBANK-1:0]         restart;
    tmr_t [NBANK-1:0]         tmr_q, tmr_d;
    cnt_t                     cnt_act_q, cnt_act_d, cnt_pre_q, cnt_pre_d;
    cnt_t                     cnt_rd_q, cnt_rd_d, cnt_wr_q, cnt_wr_d;
    cnt_t                     cnt_ref_q, cnt_ref_d, cnt_mrs_q, cnt_mrs_d;
    cnt_t                     err_count_q, err_count_d;
    logic                     err_valid_q, err_valid_d;
    logic [2:0]               err_code_q, err_code_d;
    logic [BANKBITS-1:0]      err_bank_q, err_bank_d;
    logic [2:0]               first_err_code_q, first_err_code_d;
    logic [BANKBITS-1:0]      first_err_bank_q, first_err_bank_d;
    logic [2:0]               code;
    logic [BANKBITS-1:0]      ebank;

    // Only a[10] matters to the monitor; the rest of the address is observed only.
    logic unused_a;
    assign unused_a = ^a;

    assign cmd_vld = cke & ~cs_n;
    assign cmd     = cmd_e'({ras_n, cas_n, we_n});
    assign ap      = a[10];

    function automatic cnt_t sat_inc(input cnt_t c, input logic en);
        return (en && (c != '1)) ? c + cnt_t'(1) : c;
    endfunction

    // Command decode, legality checks and next bank state.
    always_comb begin
        bank_open_d = bank_open_q;
        restart     = '0;
        code        = ERR_NONE;
        ebank       = ba;
        if (cmd_vld) begin
            case (cmd)
                CMD_ACT: begin
                    if (bank_open_q[ba])          code = ERR_ACT_OPEN;
                    else if (tmr_q[ba] < TRP_T)   code = ERR_TRP;
                    bank_open_d[ba] = 1'b1;
                    restart[ba]     = 1'b1;
                end
                CMD_PRE: begin
                    if (ap) begin
                        // Descending scan so the lowest violating bank wins.
                        for (int i = NBANK-1; i >= 0; i--) begin
                            if (bank_open_q[i] && (tmr_q[i] < TRAS_T)) begin
                                code  = ERR_TRAS;
                                ebank = BANKBITS'(i);
                            end
                        end
                        restart     = bank_open_q;
                        bank_open_d = '0;
                    end else if (bank_open_q[ba]) begin
                        if (tmr_q[ba] < TRAS_T) code = ERR_TRAS;
                        bank_open_d[ba] = 1'b0;
                        restart[ba]     = 1'b1;
                    end
                end
                CMD_RD, CMD_WR: begin
                    if (!bank_open_q[ba]) begin
                        code = ERR_CLOSED;
                    end else begin
                        if (tmr_q[ba] < TRCD_T) code = ERR_TRCD;
                        // Auto-precharge closes the bank after the access.
                        if (ap) begin
                            bank_open_d[ba] = 1'b0;
                            restart[ba]     = 1'b1;
                        end
                    end
                end
                CMD_REF: begin
                    // Report the lowest open bank as the offender.
                    if (|bank_open_q) begin
                        code = ERR_REF_OPEN;
                        for (int i = NBANK-1; i >= 0; i--)
                            if (bank_open_q[i]) ebank = BANKBITS'(i);
                    end
                end
                default: ;
            endcase
        end
    end

    // Per-bank timers restart at 1 after ACT/effective PRE and saturate at TMAX.
    always_comb begin
        tmr_d = tmr_q;
        for (int i = 0; i < NBANK; i++) begin
            if (restart[i])           tmr_d[i] = tmr_t'(1);
            else if (tmr_q[i] < TMAX_T) tmr_d[i] = tmr_q[i] + tmr_t'(1);
        end
    end

    // Counters and error reporting next-state.
    always_comb begin
        cnt_act_d        = sat_inc(cnt_act_q, cmd_vld && (cmd == CMD_ACT));
        cnt_pre_d        = sat_inc(cnt_pre_q, cmd_vld && (cmd == CMD_PRE));
        cnt_rd_d         = sat_inc(cnt_rd_q,  cmd_vld && (cmd == CMD_RD));
        cnt_wr_d         = sat_inc(cnt_wr_q,  cmd_vld && (cmd == CMD_WR));
        cnt_ref_d        = sat_inc(cnt_ref_q, cmd_vld && (cmd == CMD_REF));
        cnt_mrs_d        = sat_inc(cnt_mrs_q, cmd_vld && (cmd == CMD_MRS));
        err_valid_d      = (code != ERR_NONE);
        err_code_d       = code;
        err_bank_d       = err_valid_d ? ebank : '0;
        err_count_d      = sat_inc(err_count_q, err_valid_d);
        first_err_code_d = first_err_code_q;
        first_err_bank_d = first_err_bank_q;
        if (err_valid_d && (first_err_code_q == ERR_NONE)) begin
            first_err_code_d = code;
            first_err_bank_d = ebank;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_open_q      <= '0;
            tmr_q            <= {NBANK{TMAX_T}};
            cnt_act_q        <= '0;
            cnt_pre_q        <= '0;
            cnt_rd_q         <= '0;
            cnt_wr_q         <= '0;
            cnt_ref_q        <= '0;
            cnt_mrs_q        <= '0;
            err_count_q      <= '0;
            err_valid_q      <= 1'b0;
            err_code_q       <= '0;
            err_bank_q       <= '0;
            first_err_code_q <= '0;
            first_err_bank_q <= '0;
        end else begin
            bank_open_q      <= bank_open_d;
            tmr_q            <= tmr_d;
            cnt_act_q        <= cnt_act_d;
            cnt_pre_q        <= cnt_pre_d;
            cnt_rd_q         <= cnt_rd_d;
            cnt_wr_q         <= cnt_wr_d;
            cnt_ref_q        <= cnt_ref_d;
            cnt_mrs_q        <= cnt_mrs_d;
            err_count_q      <= err_count_d;
            err_valid_q      <= err_valid_d;
            err_code_q       <= err_code_d;
            err_bank_q       <= err_bank_d;
            first_err_code_q <= first_err_code_d;
            first_err_bank_q <= first_err_bank_d;
        end
    end

    assign bank_open      = bank_open_q;
    assign cnt_act        = cnt_act_q;
    assign cnt_pre        = cnt_pre_q;
    assign cnt_rd         = cnt_rd_q;
    assign cnt_wr         = cnt_wr_q;
    assign cnt_ref        = cnt_ref_q;
    assign cnt_mrs        = cnt_mrs_q;
    assign err_valid      = err_valid_q;
    assign err_code       = err_code_q;
    assign err_bank       = err_bank_q;
    assign err_count      = err_count_q;
    assign first_err_code = first_err_code_q;
    assign first_err_bank = first_err_bank_q;

endmodule

// File: tb/tb_ddr3_cmd_monitor.sv
// Bench for ddr3_cmd_monitor: directed scenarios plus random command traffic,
// every cycle compared against a cycle-stamp reference model.
module tb_ddr3_cmd_monitor;
    localparam int NB = 8;
    localparam int TRCD = 5, TRP = 5, TRAS = 15;

    localparam bit [2:0] C_MRS = 3'b000, C_REF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011;
    localparam bit [2:0] C_WR = 3'b100, C_RD = 3'b101, C_ZQ = 3'b110, C_NOP = 3'b111;

    logic clk = 1'b0;
    logic rst, cke, cs_n, ras_n, cas_n, we_n;
    logic [2:0]  ba;
    logic [13:0] a;
    logic [7:0]  bank_open;
    logic [31:0] cnt_act, cnt_pre, cnt_rd, cnt_wr, cnt_ref, cnt_mrs, err_count;
    logic        err_valid;
    logic [2:0]  err_code, err_bank, first_err_code, first_err_bank;

    logic [3:0]  cnt_ref_s;
    logic [7:0]  unused_s_open;
    logic [3:0]  unused_s_act, unused_s_pre, unused_s_rd, unused_s_wr, unused_s_mrs, unused_s_ecnt;
    logic        unused_s_ev;
    logic [2:0]  unused_s_code, unused_s_bank, unused_s_fcode, unused_s_fbank;

    ddr3_cmd_monitor dut (
        .clk(clk), .rst(rst), .cke(cke), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n),
        .we_n(we_n), .ba(ba), .a(a), .bank_open(bank_open),
        .cnt_act(cnt_act), .cnt_pre(cnt_pre), .cnt_rd(cnt_rd), .cnt_wr(cnt_wr),
        .cnt_ref(cnt_ref), .cnt_mrs(cnt_mrs), .err_valid(err_valid), .err_code(err_code),
        .err_bank(err_bank), .err_count(err_count), .first_err_code(first_err_code),
        .first_err_bank(first_err_bank));

    // Narrow-counter instance on the same pins, used for saturation.
    ddr3_cmd_monitor #(.CNT_WIDTH(4)) dut_s (
        .clk(clk), .rst(rst), .cke(cke), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n),
        .we_n(we_n), .ba(ba), .a(a), .bank_open(unused_s_open),
        .cnt_act(unused_s_act), .cnt_pre(unused_s_pre), .cnt_rd(unused_s_rd), .cnt_wr(unused_s_wr),
        .cnt_ref(cnt_ref_s), .cnt_mrs(unused_s_mrs), .err_valid(unused_s_ev), .err_code(unused_s_code),
        .err_bank(unused_s_bank), .err_count(unused_s_ecnt), .first_err_code(unused_s_fcode),
        .first_err_bank(unused_s_fbank));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_pass = 0;

    // Reference model: open flags and the edge index of the last ACT/PRE per bank.
    bit [NB-1:0] m_open;
    int m_last [NB];
    int m_cnt [6];   // act, pre, rd, wr, ref, mrs
    int m_ref_s, m_code, m_bank, m_ecnt, m_fcode, m_fbank;
    bit m_ev;

    task automatic chk(input string tag, input string what, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
    endtask

    task automatic model_reset();
        m_open = '0;
        for (int i = 0; i < NB; i++) m_last[i] = -1000;
        for (int i = 0; i < 6; i++) m_cnt[i] = 0;
        m_ref_s = 0; m_ev = 0; m_code = 0; m_bank = 0; m_ecnt = 0; m_fcode = 0; m_fbank = 0;
    endtask

    task automatic model_cmd(input bit ck, input bit csn, input bit [2:0] c, input int b, input bit a10);
        int n;
        int code;
        int eb;
        n = cyc + 1;
        code = 0;
        eb = b;
        if (ck && !csn) begin
            case (c)
                C_ACT: begin
                    m_cnt[0]++;
                    if (m_open[b]) code = 1;
                    else if (n - m_last[b] < TRP) code = 4;
                    m_open[b] = 1; m_last[b] = n;
                end
                C_PRE: begin
                    m_cnt[1]++;
                    if (a10) begin
                        for (int i = 0; i < NB; i++)
                            if (m_open[i]) begin
                                if (code == 0 && n - m_last[i] < TRAS) begin code = 5; eb = i; end
                                m_last[i] = n;
                            end
                        m_open = '0;
                    end else if (m_open[b]) begin
                        if (n - m_last[b] < TRAS) code = 5;
                        m_open[b] = 0; m_last[b] = n;
                    end
                end
                C_RD, C_WR: begin
                    if (c == C_RD) m_cnt[2]++; else m_cnt[3]++;
                    if (!m_open[b]) code = 2;
                    else begin
                        if (n - m_last[b] < TRCD) code = 3;
                        if (a10) begin m_open[b] = 0; m_last[b] = n; end
                    end
                end
                C_REF: begin
                    m_cnt[4]++;
                    if (m_ref_s < 15) m_ref_s++;
                    if (m_open != 0) begin
                        code = 6;
                        for (int i = NB - 1; i >= 0; i--) if (m_open[i]) eb = i;
                    end
                end
                C_MRS: m_cnt[5]++;
                default: ;
            endcase
        end
        m_ev = (code != 0);
        m_code = code;
        m_bank = m_ev ? eb : 0;
        if (m_ev) begin
            m_ecnt++;
            if (m_fcode == 0) begin m_fcode = code; m_fbank = eb; end
        end
    endtask

    task automatic check_all(input string tag);
        chk(tag, "bank_open", bank_open, m_open);
        chk(tag, "err_valid", err_valid, m_ev);
        chk(tag, "err_code", err_code, m_code);
        chk(tag, "err_bank", err_bank, m_bank);
        chk(tag, "err_count", err_count, m_ecnt);
        chk(tag, "first_err_code", first_err_code, m_fcode);
        chk(tag, "first_err_bank", first_err_bank, m_fbank);
        chk(tag, "cnt_act", cnt_act, m_cnt[0]);
        chk(tag, "cnt_pre", cnt_pre, m_cnt[1]);
        chk(tag, "cnt_rd", cnt_rd, m_cnt[2]);
        chk(tag, "cnt_wr", cnt_wr, m_cnt[3]);
        chk(tag, "cnt_ref", cnt_ref, m_cnt[4]);
        chk(tag, "cnt_mrs", cnt_mrs, m_cnt[5]);
        chk(tag, "cnt_ref_s", cnt_ref_s, m_ref_s);
    endtask

    // One command slot: drive at negedge, sample 1 time unit after the edge, then idle pins.
    task automatic step(input bit ck, input bit csn, input bit [2:0] c, input int b, input bit a10, input string tag);
        @(negedge clk);
        cke = ck; cs_n = csn; {ras_n, cas_n, we_n} = c;
        ba = 3'(b); a = 14'($urandom); a[10] = a10;
        model_cmd(ck, csn, c, b, a10);
        @(posedge clk);
        #1;
        check_all(tag);
        cke = 1'b1; cs_n = 1'b1; {ras_n, cas_n, we_n} = C_NOP;
    endtask

    task automatic cmd(input bit [2:0] c, input int b, input bit a10, input string tag);
        step(1'b1, 1'b0, c, b, a10, tag);
    endtask

    task automatic nop(input int k);
        for (int i = 0; i < k; i++) cmd(C_NOP, 0, 1'b0, "nop");
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1; cke = 1'b1; cs_n = 1'b1; {ras_n, cas_n, we_n} = C_NOP;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cke = 1'b1; cs_n = 1'b1; {ras_n, cas_n, we_n} = C_NOP; ba = '0; a = '0;
        model_reset();

        // Legal ACT/RD/PRE/ACT sequence on bank 2
        do_reset("rst0");
        cmd(C_ACT, 2, 0, "tp1_act"); nop(4);
        cmd(C_RD, 2, 0, "tp1_rd");   nop(9);
        cmd(C_PRE, 2, 0, "tp1_pre"); nop(4);
        cmd(C_ACT, 2, 0, "tp1_act2");
        chk("tp1", "cnt_act", cnt_act, 2);
        chk("tp1", "cnt_rd", cnt_rd, 1);
        chk("tp1", "cnt_pre", cnt_pre, 1);
        chk("tp1", "bank_open", bank_open, 8'h04);
        chk("tp1", "err_count", err_count, 0);

        // tRCD violation
        do_reset("rst1");
        cmd(C_ACT, 1, 0, "tp2_act"); nop(3);
        cmd(C_WR, 1, 0, "tp2_wr");
        chk("tp2", "err_valid", err_valid, 1);
        chk("tp2", "err_code", err_code, 3);
        chk("tp2", "err_bank", err_bank, 1);
        chk("tp2", "first_err_code", first_err_code, 3);
        chk("tp2", "err_count", err_count, 1);
        nop(1);
        chk("tp2", "err_valid_drop", err_valid, 0);

        // PREA with two tRAS violations reports lowest bank once
        do_reset("rst2");
        cmd(C_ACT, 0, 0, "tp3_act0");
        cmd(C_ACT, 3, 0, "tp3_act3"); nop(8);
        cmd(C_PRE, 5, 1, "tp3_prea");
        chk("tp3", "err_code", err_code, 5);
        chk("tp3", "err_bank", err_bank, 0);
        chk("tp3", "bank_open", bank_open, 0);
        chk("tp3", "err_count", err_count, 1);

        // Closed-bank read then REF with an open bank
        do_reset("rst3");
        cmd(C_RD, 5, 0, "tp4_rd");
        chk("tp4", "err_code", err_code, 2);
        chk("tp4", "err_bank", err_bank, 5);
        nop(1);
        cmd(C_ACT, 0, 0, "tp4_act");
        cmd(C_REF, 3, 0, "tp4_ref");
        chk("tp4", "err_code_ref", err_code, 6);
        chk("tp4", "first_err_code", first_err_code, 2);
        chk("tp4", "err_count", err_count, 2);

        // CKE low ignores commands; reset mid-sequence
        do_reset("rst4");
        cmd(C_ACT, 4, 0, "tp5_act");
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, C_ACT, $urandom_range(0, 7), 1'b0, "tp5_ckelow");
        chk("tp5", "cnt_act", cnt_act, 1);
        chk("tp5", "bank_open", bank_open, 8'h10);
        do_reset("tp5_rst");
        chk("tp5", "bank_open_rst", bank_open, 0);
        chk("tp5", "cnt_act_rst", cnt_act, 0);
        cmd(C_ACT, 4, 0, "tp5_act_after");
        chk("tp5", "err_valid_after", err_valid, 0);
        chk("tp5", "bank_open_after", bank_open, 8'h10);

        // Saturation on the 4-bit instance
        do_reset("rst5");
        for (int i = 0; i < 20; i++) begin cmd(C_REF, 0, 0, "tp6_ref"); nop(1); end
        chk("tp6", "cnt_ref_s", cnt_ref_s, 15);
        chk("tp6", "cnt_ref", cnt_ref, 20);

        // Random traffic
        do_reset("rst6");
        for (int i = 0; i < 600; i++) begin
            int r;
            bit [2:0] c;
            if (i == 300) do_reset("rnd_rst");
            r = $urandom_range(0, 99);
            if (r < 45)      c = C_NOP;
            else if (r < 60) c = C_ACT;
            else if (r < 72) c = C_PRE;
            else if (r < 82) c = C_RD;
            else if (r < 92) c = C_WR;
            else if (r < 95) c = C_REF;
            else if (r < 98) c = C_MRS;
            else             c = C_ZQ;
            step(($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0), c,
                 $urandom_range(0, 3), ($urandom_range(0, 3) == 0), "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
